// File: rtl/imm_ext_pkg.sv
// Shared encodings for the immediate-extension pipeline: extension modes,
// skid-buffer states and the transfer-counter width.
package imm_ext_pkg;

  // Extension mode encodings, sampled alongside the raw immediate.
  localparam logic [1:0] MODE_SEXT     = 2'b00;
  localparam logic [1:0] MODE_ZEXT     = 2'b01;
  localparam logic [1:0] MODE_SEXT_SH1 = 2'b10;
  localparam logic [1:0] MODE_UPPER    = 2'b11;

  // Skid-buffer occupancy states.
  typedef logic [1:0] state_t;
  localparam state_t ST_EMPTY = 2'b00;
  localparam state_t ST_ONE   = 2'b01;
  localparam state_t ST_TWO   = 2'b10;

  // Width of the accepted-transfer counter.
  localparam int unsigned CNT_W = 16;

endpackage : imm_ext_pkg

// File: rtl/imm_ext_core.sv
// Combinational immediate extender: raw field plus mode -> OUT_W-bit result.
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int unsigned IN_W  = 13,
  parameter int unsigned OUT_W = 32
) (
  input  logic [IN_W-1:0]  unext_i,
  input  logic [1:0]       mode_i,
  output logic [OUT_W-1:0] result_o
);

  localparam int unsigned PAD_W = OUT_W - IN_W;

  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] zext;
  logic [OUT_W-1:0] upper;

  assign sext  = {{PAD_W{unext_i[IN_W-1]}}, unext_i};
  assign zext  = {{PAD_W{1'b0}}, unext_i};
  assign upper = {unext_i, {PAD_W{1'b0}}};

  // Select the extended form for the requested mode.
  always_comb begin
    result_o = '0;
    case (mode_i)
      MODE_SEXT:     result_o = sext;
      MODE_ZEXT:     result_o = zext;
      MODE_SEXT_SH1: result_o = {sext[OUT_W-2:0], 1'b0};
      MODE_UPPER:    result_o = upper;
      default:       result_o = '0;
    endcase
  end

endmodule : imm_ext_core

// File: rtl/imm_ext_pipe.sv
// Immediate-extension pipeline: results are extended at acceptance and held
// in a two-entry skid buffer (output register + skid register), with a
// free-running count of accepted input transfers.
module imm_ext_pipe
  import imm_ext_pkg::*;
#(
  parameter int unsigned IN_W  = 13,
  parameter int unsigned OUT_W = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [IN_W-1:0]  UNEXT,
  input  logic [1:0]       MODE,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [OUT_W-1:0] EXT,
  output logic [CNT_W-1:0] ACCEPT_CNT
);

  state_t             state_q, state_d;
  logic [OUT_W-1:0]   out_q, out_d;
  logic [OUT_W-1:0]   skid_q, skid_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [OUT_W-1:0]   result;
  logic               accept;
  logic               consume;

  imm_ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .unext_i  (UNEXT),
    .mode_i   (MODE),
    .result_o (result)
  );

  // Handshake outputs decode from state only, so OUT_READY never reaches IN_READY.
  assign IN_READY   = (state_q != ST_TWO);
  assign OUT_VALID  = (state_q != ST_EMPTY);
  assign EXT        = out_q;
  assign ACCEPT_CNT = cnt_q;

  assign accept  = IN_VALID & IN_READY;
  assign consume = OUT_VALID & OUT_READY;

  // Skid-buffer next-state and data movement.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d = ST_ONE;
          out_d   = result;
        end
      end
      ST_ONE: begin
        if (accept && !consume) begin
          state_d = ST_TWO;
          skid_d  = result;
        end else if (!accept && consume) begin
          state_d = ST_EMPTY;
        end else if (accept && consume) begin
          out_d   = result;
        end
      end
      ST_TWO: begin
        // IN_READY is low here, so only a consume can move the buffer.
        if (consume) begin
          state_d = ST_ONE;
          out_d   = skid_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Accepted-transfer counter, wrapping naturally at its width.
  always_comb begin
    cnt_d = cnt_q;
    if (accept) cnt_d = cnt_q + 1'b1;
  end

  // State, data and counter registers with asynchronous clear.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule : imm_ext_pipe

// File: tb/tb_imm_ext_pipe.sv
// Directed self-checking bench for imm_ext_pipe (default and narrow widths).
module tb_imm_ext_pipe;

  logic        CLK;
  logic        RST_N;
  logic        IN_VALID, IN_READY, OUT_VALID, OUT_READY;
  logic [12:0] UNEXT;
  logic [1:0]  MODE;
  logic [31:0] EXT;
  logic [15:0] ACCEPT_CNT;

  // Narrow instance for the parameter sweep.
  logic        n_in_valid, n_in_ready, n_out_valid, n_out_ready;
  logic [4:0]  n_unext;
  logic [1:0]  n_mode;
  logic [15:0] n_ext;
  logic [15:0] n_cnt;

  int checks = 0;
  int errors = 0;

  imm_ext_pipe #(.IN_W(13), .OUT_W(32)) dut (
    .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .UNEXT(UNEXT), .MODE(MODE), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .EXT(EXT), .ACCEPT_CNT(ACCEPT_CNT)
  );

  imm_ext_pipe #(.IN_W(5), .OUT_W(16)) dut_n (
    .CLK(CLK), .RST_N(RST_N), .IN_VALID(n_in_valid), .IN_READY(n_in_ready),
    .UNEXT(n_unext), .MODE(n_mode), .OUT_VALID(n_out_valid), .OUT_READY(n_out_ready),
    .EXT(n_ext), .ACCEPT_CNT(n_cnt)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic [12:0] unext;
    logic [1:0]  mode;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [4:0]  unext;
    logic [1:0]  mode;
    logic [15:0] exp;
  } nvec_t;

  vec_t  vecs[6];
  nvec_t nvecs[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    vecs[0] = '{13'h1000, 2'b00, 32'hFFFFF000};
    vecs[1] = '{13'h1000, 2'b01, 32'h00001000};
    vecs[2] = '{13'h1000, 2'b10, 32'hFFFFE000};
    vecs[3] = '{13'h1000, 2'b11, 32'h80000000};
    vecs[4] = '{13'h1FFF, 2'b11, 32'hFFF80000};
    vecs[5] = '{13'h1FFF, 2'b01, 32'h00001FFF};
    nvecs[0] = '{5'h10, 2'b00, 16'hFFF0};
    nvecs[1] = '{5'h10, 2'b01, 16'h0010};
    nvecs[2] = '{5'h10, 2'b10, 16'hFFE0};
    nvecs[3] = '{5'h10, 2'b11, 16'h8000};

    RST_N = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b0; UNEXT = '0; MODE = '0;
    n_in_valid = 1'b0; n_out_ready = 1'b0; n_unext = '0; n_mode = '0;
    #1 RST_N = 1'b0;
    #1;
    chk("rst_out_valid", OUT_VALID, 0);
    chk("rst_in_ready", IN_READY, 1);
    chk("rst_ext", EXT, 0);
    chk("rst_cnt", ACCEPT_CNT, 0);
    @(posedge CLK); #2 RST_N = 1'b1;
    step();

    // Streaming mode table with OUT_READY high: one-cycle latency.
    OUT_READY = 1'b1;
    for (int i = 0; i < 6; i++) begin
      IN_VALID = 1'b1; UNEXT = vecs[i].unext; MODE = vecs[i].mode;
      step();
      chk($sformatf("tbl_ext%0d", i), EXT, vecs[i].exp);
      chk($sformatf("tbl_vld%0d", i), OUT_VALID, 1);
      if (i == 3) chk("tbl_cnt4", ACCEPT_CNT, 4);
    end
    IN_VALID = 1'b0;
    step();
    chk("drain_vld", OUT_VALID, 0);
    chk("cnt6", ACCEPT_CNT, 6);

    // Backpressure: A and B fill the buffer, C must wait.
    OUT_READY = 1'b0; IN_VALID = 1'b1; MODE = 2'b00; UNEXT = 13'h0001;
    step();
    chk("bp_a_ext", EXT, 32'h1);
    chk("bp_a_rdy", IN_READY, 1);
    UNEXT = 13'h0002;
    step();
    chk("bp_b_rdy", IN_READY, 0);
    chk("bp_b_ext", EXT, 32'h1);
    UNEXT = 13'h0003;
    step();
    step();
    chk("bp_hold_ext", EXT, 32'h1);
    chk("bp_hold_rdy", IN_READY, 0);
    chk("bp_hold_cnt", ACCEPT_CNT, 8);
    OUT_READY = 1'b1;
    step();
    chk("bp_out_b", EXT, 32'h2);
    chk("bp_rdy_again", IN_READY, 1);
    OUT_READY = 1'b0;
    step();
    chk("bp_b_held", EXT, 32'h2);
    chk("bp_c_taken", IN_READY, 0);
    IN_VALID = 1'b0;
    step();
    chk("bp_b_held2", EXT, 32'h2);
    OUT_READY = 1'b1;
    step();
    chk("bp_out_c", EXT, 32'h3);
    chk("bp_out_c_vld", OUT_VALID, 1);
    step();
    chk("bp_empty", OUT_VALID, 0);
    chk("bp_cnt", ACCEPT_CNT, 9);

    // Sustained accept+consume in ONE.
    IN_VALID = 1'b1; MODE = 2'b01;
    for (int k = 0; k < 9; k++) begin
      UNEXT = 13'(k + 32);
      step();
      chk($sformatf("one_ext%0d", k), EXT, 32'(k + 32));
      chk($sformatf("one_rdy%0d", k), IN_READY, 1);
      chk($sformatf("one_vld%0d", k), OUT_VALID, 1);
    end
    IN_VALID = 1'b0;
    step();
    chk("one_cnt", ACCEPT_CNT, 18);

    // Fill to TWO, then reset between edges.
    OUT_READY = 1'b0; IN_VALID = 1'b1; MODE = 2'b00;
    step();
    step();
    IN_VALID = 1'b0;
    chk("two_rdy", IN_READY, 0);
    #1 RST_N = 1'b0;
    #1;
    chk("mid_rst_vld", OUT_VALID, 0);
    chk("mid_rst_rdy", IN_READY, 1);
    chk("mid_rst_cnt", ACCEPT_CNT, 0);
    chk("mid_rst_ext", EXT, 0);
    #1 RST_N = 1'b1;
    IN_VALID = 1'b1; UNEXT = 13'h0FFF; MODE = 2'b00; OUT_READY = 1'b1;
    step();
    chk("post_rst_ext", EXT, 32'h00000FFF);
    chk("post_rst_cnt", ACCEPT_CNT, 1);
    IN_VALID = 1'b0;
    step();

    // Narrow-width instance.
    n_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_in_valid = 1'b1; n_unext = nvecs[i].unext; n_mode = nvecs[i].mode;
      step();
      chk($sformatf("narrow_ext%0d", i), n_ext, nvecs[i].exp);
    end
    n_in_valid = 1'b0;

    // No transfer is recorded while reset is held across an edge.
    IN_VALID = 1'b1; OUT_READY = 1'b1;
    RST_N = 1'b0;
    step();
    chk("rst_edge_cnt", ACCEPT_CNT, 0);
    chk("rst_edge_vld", OUT_VALID, 0);
    RST_N = 1'b1;

    // Counter wrap after 65536 accepts.
    for (int n = 0; n < 65535; n++) step();
    chk("cnt_ffff", ACCEPT_CNT, 16'hFFFF);
    step();
    chk("cnt_wrap", ACCEPT_CNT, 16'h0000);
    IN_VALID = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_imm_ext_pipe
